// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside decode: shadows in-flight register
// writes per stage and derives the decode stall and the rs/rt forward selects.
module hazard_scoreboard #(
   parameter int AW      = 5,
   parameter int DEPTH   = 4,
   parameter int MUL_LAT = 3,
   parameter int SW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          freeze,
   input  logic          issue_valid,
   input  logic          issue_we,
   input  logic [AW-1:0] issue_waddr,
   input  logic [1:0]    issue_class,
   input  logic          rs_used,
   input  logic          rt_used,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic          stall,
   output logic [SW-1:0] fwd_rs_sel,
   output logic [SW-1:0] fwd_rt_sel,
   output logic [15:0]   stall_count
);

   logic          r_valid [1:DEPTH];
   logic [AW-1:0] r_addr  [1:DEPTH];
   logic [SW-1:0] r_avail [1:DEPTH];
   logic [15:0]   r_stall_count;

   logic [DEPTH:1] w_rs_match;
   logic [DEPTH:1] w_rt_match;
   logic           w_rs_hit;
   logic           w_rt_hit;
   logic [SW-1:0]  w_rs_k;
   logic [SW-1:0]  w_rt_k;
   logic [SW-1:0]  w_rs_av;
   logic [SW-1:0]  w_rt_av;
   logic           w_rs_haz;
   logic           w_rt_haz;
   logic           w_stall;
   logic           w_insert;

   // Stage at which a class result reaches a forwarding bus; reserved class behaves as ALU.
   function automatic logic [SW-1:0] class_avail(input logic [1:0] cls);
      logic [SW-1:0] v;
      case (cls)
         2'd1:    v = SW'(2);
         2'd2:    v = SW'(MUL_LAT);
         default: v = SW'(1);
      endcase
      return v;
   endfunction

   // Operand matching with youngest-entry priority: scan oldest to youngest, last hit wins.
   always_comb begin
      w_rs_hit = 1'b0;
      w_rt_hit = 1'b0;
      w_rs_k   = '0;
      w_rt_k   = '0;
      w_rs_av  = '0;
      w_rt_av  = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         w_rs_match[k] = r_valid[k] && (r_addr[k] == rs_addr) && (rs_addr != '0) && rs_used;
         w_rt_match[k] = r_valid[k] && (r_addr[k] == rt_addr) && (rt_addr != '0) && rt_used;
      end
      for (int k = DEPTH; k >= 1; k--) begin
         w_rs_hit = w_rs_match[k] ? 1'b1       : w_rs_hit;
         w_rs_k   = w_rs_match[k] ? SW'(k)     : w_rs_k;
         w_rs_av  = w_rs_match[k] ? r_avail[k] : w_rs_av;
         w_rt_hit = w_rt_match[k] ? 1'b1       : w_rt_hit;
         w_rt_k   = w_rt_match[k] ? SW'(k)     : w_rt_k;
         w_rt_av  = w_rt_match[k] ? r_avail[k] : w_rt_av;
      end
   end

   assign w_rs_haz = w_rs_hit && (w_rs_k < w_rs_av);
   assign w_rt_haz = w_rt_hit && (w_rt_k < w_rt_av);
   assign w_stall  = issue_valid && (w_rs_haz || w_rt_haz) && !freeze;
   assign w_insert = issue_valid && issue_we && (issue_waddr != '0) && !w_stall && !freeze;

   assign stall       = w_stall;
   assign fwd_rs_sel  = (w_rs_hit && !w_rs_haz && !w_stall) ? w_rs_k : '0;
   assign fwd_rt_sel  = (w_rt_hit && !w_rt_haz && !w_stall) ? w_rt_k : '0;
   assign stall_count = r_stall_count;

   // Shadow pipeline: shifts on every unfrozen cycle, stage 1 takes a bubble unless inserting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= DEPTH; k++) begin
            r_valid[k] <= 1'b0;
            r_addr[k]  <= '0;
            r_avail[k] <= '0;
         end
      end else if (!freeze) begin
         for (int k = DEPTH; k >= 2; k--) begin
            r_valid[k] <= r_valid[k-1];
            r_addr[k]  <= r_addr[k-1];
            r_avail[k] <= r_avail[k-1];
         end
         r_valid[1] <= w_insert;
         r_addr[1]  <= issue_waddr;
         r_avail[1] <= class_avail(issue_class);
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= 16'h0000;
      end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'h0001;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a history-based reference model pushes
// expected outputs per cycle, a monitor pops and compares them.
module tb_hazard_scoreboard;
   localparam int AW      = 5;
   localparam int DEPTH   = 4;
   localparam int MUL_LAT = 3;
   localparam int SW      = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          freeze = 1'b0;
   logic          issue_valid = 1'b0;
   logic          issue_we = 1'b0;
   logic [AW-1:0] issue_waddr = '0;
   logic [1:0]    issue_class = 2'd0;
   logic          rs_used = 1'b0;
   logic          rt_used = 1'b0;
   logic [AW-1:0] rs_addr = '0;
   logic [AW-1:0] rt_addr = '0;
   logic          stall;
   logic [SW-1:0] fwd_rs_sel;
   logic [SW-1:0] fwd_rt_sel;
   logic [15:0]   stall_count;

   always #5 clk = ~clk;

   hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .SW(SW)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .issue_valid(issue_valid),
      .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_class(issue_class),
      .rs_used(rs_used), .rt_used(rt_used), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .stall_count(stall_count)
   );

   typedef struct packed {
      logic          stall;
      logic [SW-1:0] rs;
      logic [SW-1:0] rt;
      logic [15:0]   cnt;
   } exp_t;

   typedef struct {
      int unsigned   ins;
      logic [AW-1:0] addr;
      int            avail;
   } ent_t;

   exp_t        exp_q[$];
   ent_t        hist[$];
   int unsigned shifts = 0;
   int unsigned model_cnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   function automatic int avail_of(input logic [1:0] cls);
      if (cls == 2'd1) return 2;
      else if (cls == 2'd2) return MUL_LAT;
      else return 1;
   endfunction

   // Youngest write to the register still inside the tracked window; stage = shifts since insert.
   function automatic void lookup(input logic used, input logic [AW-1:0] a,
                                  output bit hit, output int k, output int av);
      hit = 1'b0; k = 0; av = 0;
      if (used && a != '0) begin
         for (int i = hist.size() - 1; i >= 0; i--) begin
            int st;
            st = int'(shifts - hist[i].ins) + 1;
            if (st <= DEPTH && hist[i].addr == a) begin
               hit = 1'b1; k = st; av = hist[i].avail;
               break;
            end
         end
      end
   endfunction

   task automatic model_step();
      bit hs, ht, zs, zt, st;
      int ks, kt, as_, at;
      exp_t e;
      ent_t n;
      lookup(rs_used, rs_addr, hs, ks, as_);
      lookup(rt_used, rt_addr, ht, kt, at);
      zs = hs && (ks < as_);
      zt = ht && (kt < at);
      st = issue_valid && (zs || zt) && !freeze;
      e.stall = st;
      e.rs    = (hs && !zs && !st) ? SW'(ks) : '0;
      e.rt    = (ht && !zt && !st) ? SW'(kt) : '0;
      e.cnt   = 16'(model_cnt);
      exp_q.push_back(e);
      if (st && model_cnt < 32'hFFFF) model_cnt++;
      if (!freeze) begin
         shifts++;
         if (issue_valid && issue_we && issue_waddr != '0 && !st) begin
            n.ins = shifts; n.addr = issue_waddr; n.avail = avail_of(issue_class);
            hist.push_back(n);
         end
         while (hist.size() > 0 && int'(shifts - hist[0].ins) + 1 > DEPTH) void'(hist.pop_front());
      end
   endtask

   task automatic drive(input logic v, input logic we, input int wa, input int cls,
                        input logic rsu, input int rsa, input logic rtu, input int rta,
                        input logic frz);
      @(negedge clk);
      issue_valid = v; issue_we = we; issue_waddr = AW'(wa); issue_class = 2'(cls);
      rs_used = rsu; rs_addr = AW'(rsa); rt_used = rtu; rt_addr = AW'(rta); freeze = frz;
      #1 model_step();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   // Monitor: compares DUT outputs each cycle against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_stall", int'(stall), int'(e.stall));
            check("sb_rs_sel", int'(fwd_rs_sel), int'(e.rs));
            check("sb_rt_sel", int'(fwd_rt_sel), int'(e.rt));
            check("sb_count", int'(stall_count), int'(e.cnt));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check("rst_stall", int'(stall), 0);
      check("rst_rs_sel", int'(fwd_rs_sel), 0);
      check("rst_rt_sel", int'(fwd_rt_sel), 0);
      check("rst_count", int'(stall_count), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU chain: selects follow the producer down the pipe, then fall back to the register file
      idle();
      drive(1'b1, 1'b1, 3, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      for (int i = 1; i <= DEPTH + 1; i++) begin
         drive(1'b1, 1'b0, 0, 0, 1'b1, 3, 1'b0, 0, 1'b0);
         check("alu_stall", int'(stall), 0);
         check("alu_sel", int'(fwd_rs_sel), (i <= DEPTH) ? i : 0);
      end

      // Load-use
      drive(1'b1, 1'b1, 5, 1, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
      check("ld_stall", int'(stall), 1);
      check("ld_sel_stalled", int'(fwd_rs_sel), 0);
      drive(1'b1, 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
      check("ld_go", int'(stall), 0);
      check("ld_sel", int'(fwd_rs_sel), 2);
      idle();
      check("ld_count", int'(stall_count), 1);

      // MUL on rt
      drive(1'b1, 1'b1, 7, 2, 1'b0, 0, 1'b0, 0, 1'b0);
      for (int i = 0; i < MUL_LAT - 1; i++) begin
         drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 1'b0);
         check("mul_stall", int'(stall), 1);
      end
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 1'b0);
      check("mul_go", int'(stall), 0);
      check("mul_sel", int'(fwd_rt_sel), MUL_LAT);
      idle();
      check("mul_count", int'(stall_count), 3);

      // WAW: younger ALU write shadows the older MUL
      drive(1'b1, 1'b1, 4, 2, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b1, 4, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b1, 4, 1'b0, 0, 1'b0);
      check("waw_stall", int'(stall), 0);
      check("waw_sel", int'(fwd_rs_sel), 1);

      // Register 0 is never tracked
      drive(1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b1, 0, 1'b0);
      check("r0_rs_sel", int'(fwd_rs_sel), 0);
      check("r0_rt_sel", int'(fwd_rt_sel), 0);

      // Freeze in the middle of a MUL stall
      idle();
      drive(1'b1, 1'b1, 7, 2, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 1'b0);
      check("frz_pre_stall", int'(stall), 1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 1'b1);
         check("frz_stall", int'(stall), 0);
      end
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 1'b0);
      check("frz_resume", int'(stall), 1);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 1'b0);
      check("frz_sel", int'(fwd_rt_sel), MUL_LAT);
      idle();
      check("frz_count", int'(stall_count), 5);

      // Saturation from a preloaded counter
      idle();
      #2;
      force dut.r_stall_count = 16'hFFFD;
      #1;
      release dut.r_stall_count;
      model_cnt = 32'hFFFD;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5, 1, 1'b0, 0, 1'b0, 0, 1'b0);
         drive(1'b1, 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
         drive(1'b1, 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
      end
      idle();
      check("sat_count", int'(stall_count), 16'hFFFF);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(7, 0),
               $urandom_range(3, 0), $urandom_range(3, 0) != 0, $urandom_range(7, 0),
               $urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0) == 0);
      end

      // Asynchronous reset while a stall is pending
      drive(1'b1, 1'b1, 9, 2, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b1, 9, 1'b0, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", int'(stall), 0);
      check("mid_rst_rs_sel", int'(fwd_rs_sel), 0);
      check("mid_rst_rt_sel", int'(fwd_rt_sel), 0);
      check("mid_rst_count", int'(stall_count), 0);
      hist.delete();
      model_cnt = 0;
      issue_valid = 1'b0; issue_we = 1'b0; rs_used = 1'b0; rt_used = 1'b0; freeze = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(7, 0),
               $urandom_range(3, 0), $urandom_range(3, 0) != 0, $urandom_range(7, 0),
               $urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0) == 0);
      end
      idle();

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      #3;
      check("drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the MIPS pipeline, replacing fixed EX/MEM/WB comparison logic in decode. It tracks every in-flight register write in a DEPTH-stage shift register, together with the stage at which each result becomes forwardable (ALU, load, or multi-cycle multiply). Each cycle it produces a decode stall and per-operand forward selects. It sits beside decode. Decode supplies the instruction's sources, destination and class, and uses the selects to mux rs/rt data from the corresponding stage result buses.

## Interface
Parameters:
- AW, 5, register address width; register 0 is never tracked.
- DEPTH, 4, number of tracked stages after decode (stage 1 = EX … stage DEPTH = WB); must be ≥ MUL_LAT and ≥ 2.
- MUL_LAT, 3, stage at which a MUL result becomes forwardable.
- SW, $clog2(DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- freeze  in  1  global pipeline hold (memory wait); no shift, no insert.
- issue_valid  in  1  decode holds a valid instruction.
- issue_we  in  1  instruction writes a register.
- issue_waddr  in  AW  destination register.
- issue_class  in  2  0=ALU (forwardable at stage 1), 1=LOAD (stage 2), 2=MUL (stage MUL_LAT), 3=reserved (treated as ALU).
- rs_used, rt_used  in  1  operand is actually read.
- rs_addr, rt_addr  in  AW  source registers.
- stall  out  1  decode must hold; a bubble is inserted.
- fwd_rs_sel, fwd_rt_sel  out  SW  0 = register file, k = stage-k result bus.
- stall_count  out  16  saturating count of stall cycles.

## Operation
- Per-stage state: valid, addr[AW-1:0], avail[SW-1:0] (stage at which the value becomes forwardable).
- Operand match: an entry at stage k matches when valid, addr == operand, operand ≠ 0, and operand used.
- Priority: the youngest match (smallest k) wins. Older matches are ignored.
- Operand hazard: the winning entry has k < avail.
- Forward select:
  - k of the winning entry when there is no hazard.
  - 0 when nothing matches.
  - 0 while stalled (don't-care for decode, fixed for verification).
- stall = issue_valid & (rs hazard | rt hazard) & ~freeze.
- Insert into stage 1: occurs when issue_valid & issue_we & issue_waddr ≠ 0 & ~stall & ~freeze. The new entry gets avail from its class.
- Otherwise stage 1 receives a bubble (valid=0). This includes stall cycles.
- Each non-frozen cycle, stage k+1 ← stage k. The entry leaving stage DEPTH is retired; its value is in the register file from the next cycle.
- freeze=1: all entries hold, no insert, stall=0, selects still computed from the held state.
- stall_count increments on every cycle with stall=1 and saturates at 16'hFFFF.
- Combinational paths: stall and the selects depend only on the current state and the current inputs. There is no registered output except stall_count.

## Timing
- Reset (async, rst_n=0): all valid=0, stall_count=0. Consequently stall=0 and both selects=0 immediately, without waiting for a clock edge.
- Reset release mid-operation: all in-flight entries are lost. The pipeline is flushed by the same reset.
- Dependent-instruction latency when the producer is issued at cycle t (consumer reads the same register):
  - ALU producer: consumer issues at t+1 with select=1, no stall.
  - LOAD producer:
    - consumer at t+1 stalls one cycle;
    - it issues at t+2 with select=2.
  - MUL producer:
    - consumer at t+1 stalls MUL_LAT−1 cycles;
    - it issues at t+MUL_LAT with select=MUL_LAT.
- Consumer at t+DEPTH+1 or later: select=0 (register file).
- Both operands hazard on different producers: stall until both are clear.
- The same register may appear in several stages (WAW); only the youngest entry is consulted.
- A stalled instruction that also writes is not inserted until the cycle it proceeds.
- freeze during a stall: stall deasserts, and the countdown resumes when freeze falls.

## Test plan
- Reset / idle:
  - rst_n low mid-traffic → stall=0, selects=0, stall_count=0 immediately, without a clock edge;
  - rs_addr=0 matching an entry with waddr=0 → never tracked, select 0.
- ALU chain: ADD r3 at t, ADD using r3 at t+1, t+2, t+3 → selects 1, 2, 3; stall always 0.
- Load-use: LW r5 at t, consumer of r5 at t+1 → stall=1 for exactly one cycle, then select=2; stall_count=1.
- MUL (MUL_LAT=3): MUL r7 at t, consumer of r7 on rt → 2 stall cycles, then fwd_rt_sel=3; stall_count=2.
- WAW priority: MUL r4 at t, ADD r4 at t+1, consumer of r4 at t+2 → no stall, select=1 (ALU result wins).
- Freeze / saturation:
  - freeze=1 for 5 cycles during a MUL stall → stall=0 and state held; after release the remaining stall resumes;
  - preload stall_count near 16'hFFFF → it stays at 16'hFFFF.
